// File: rtl/bit_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// bit_serial_adder_ctrl
//
// Purpose:
//   Integer add/subtract unit for the Tomasulo execution stage, built around
//   a single shared 1-bit full adder. It performs a WIDTH-bit operation
//   LSB first, one bit per clock. It accepts one operation at a time from
//   the reservation station and holds the tagged result until the CDB
//   arbiter grants it.
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous squash of any in-flight/held op
//   in_valid   in   1      operation offered
//   in_ready   out  1      unit can accept (IDLE only)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_sub     in   1      0: A+B, 1: A-B (A + ~B + 1)
//   in_tag     in   TAG_W  destination tag
//   out_valid  out  1      result held for CDB
//   out_ready  in   1      CDB grant; result consumed on out_valid&out_ready
//   out_sum    out  WIDTH  result
//   out_cout   out  1      carry out of MSB (sub: 1 = no borrow)
//   out_ovf    out  1      signed overflow
//   out_tag    out  TAG_W  tag of result
//   busy       out  1      state != IDLE
// ---------------------------------------------------------------------------
module bit_serial_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operand / sequencing registers
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;        // already conditionally inverted for subtract
    logic [TAG_W-1:0] r_tag;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;

    // Result registers: separate from the shift register so the presented
    // result never moves while a later op is being computed.
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [TAG_W-1:0] r_out_tag;

    // FSM control strobes
    logic w_accept;
    logic w_step;
    logic w_last;

    // Shared full adder
    logic w_fa_a;
    logic w_fa_b;
    logic w_fa_s;
    logic w_fa_co;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs. flush overrides everything, so no
    // accept/step strobe can fire in a flush cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_step    = 1'b0;
        w_last    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: ;
        endcase

        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_accept = 1'b1;
                        w_next   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_last = 1'b1;
                        w_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_next = ST_IDLE;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // The one and only adder on the data path
    // ------------------------------------------------------------------
    always_comb begin
        w_fa_a  = r_a[r_cnt];
        w_fa_b  = r_b[r_cnt];
        w_fa_s  = w_fa_a ^ w_fa_b ^ r_carry;
        w_fa_co = (w_fa_a & w_fa_b) | (w_fa_a & r_carry) | (w_fa_b & r_carry);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_tag     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_out_tag <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b ^ {WIDTH{in_sub}};
            r_tag   <= in_tag;
            r_carry <= in_sub;
            r_cnt   <= '0;
        end else if (w_step) begin
            // Sum bits enter at the MSB; after WIDTH steps bit 0 holds the LSB.
            r_shift <= {w_fa_s, r_shift[WIDTH-1:1]};
            r_carry <= w_fa_co;
            if (w_last) begin
                r_sum     <= {w_fa_s, r_shift[WIDTH-1:1]};
                r_cout    <= w_fa_co;
                // r_carry is the carry into the MSB at this point.
                r_ovf     <= r_carry ^ w_fa_co;
                r_out_tag <= r_tag;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;
    assign out_tag  = r_out_tag;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
module tb_bit_serial_adder_ctrl;

    localparam int WIDTH = 8;
    localparam int TAG_W = 6;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    bit_serial_adder_ctrl #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [WIDTH-1:0] last_sum;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: A + (sub ? ~B : B) + sub, overflow from operand/result signs
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub, input logic [TAG_W-1:0] tag);
        exp_t           e;
        logic [WIDTH-1:0] b2;
        logic [WIDTH:0]   full;
        b2     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, b2} + {{WIDTH{1'b0}}, sub};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (a[WIDTH-1] == b2[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        e.tag  = tag;
        return e;
    endfunction

    // Drive one op, push its expectation, return #1 after the accept edge.
    task automatic send_only(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic sub, input logic [TAG_W-1:0] tag);
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        check_val("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_tag   = tag;
        sb.push_back(model(a, b, sub, tag));
        tick();
        in_valid = 1'b0;
        // Operands must have been latched; scramble the bus.
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_sub   = ~sub;
        in_tag   = TAG_W'($urandom);
    endtask

    // Counts rising edges from accept edge (inclusive) until out_valid.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check_val("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    // Hold the result for bp cycles, compare against scoreboard, handshake.
    task automatic recv(input int bp);
        exp_t             e;
        logic [WIDTH-1:0] s0;
        logic [TAG_W-1:0] t0;
        s0 = out_sum;
        t0 = out_tag;
        for (int i = 0; i < bp; i++) begin
            tick();
            check_val("bp_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("bp_sum_stable", {24'd0, out_sum}, {24'd0, s0});
            check_val("bp_tag_stable", {26'd0, out_tag}, {26'd0, t0});
        end
        if (sb.size() == 0) begin
            check_val("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val("sum",  {24'd0, out_sum}, {24'd0, e.sum});
            check_val("cout", {31'd0, out_cout}, {31'd0, e.cout});
            check_val("ovf",  {31'd0, out_ovf}, {31'd0, e.ovf});
            check_val("tag",  {26'd0, out_tag}, {26'd0, e.tag});
            last_sum = e.sum;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check_val("post_hs_ready", {31'd0, in_ready}, 32'd1);
        check_val("post_hs_busy",  {31'd0, busy}, 32'd0);
        check_val("post_hs_sum_kept", {24'd0, out_sum}, {24'd0, last_sum});
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic [TAG_W-1:0] tag, input int bp);
        int n;
        send_only(a, b, sub, tag);
        wait_valid(n);
        check_val("latency", n, WIDTH + 1);
        recv(bp);
    endtask

    initial begin
        int  n;
        logic seen;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        last_sum  = '0;

        #23;
        check_val("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy",      {31'd0, busy}, 32'd0);
        check_val("rst_sum",       {24'd0, out_sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic add, subtracts, boundary adds
        do_op(8'h3C, 8'h05, 1'b0, 6'd9,  0);
        do_op(8'h05, 8'h06, 1'b1, 6'd17, 0);
        do_op(8'h80, 8'h01, 1'b1, 6'd33, 0);

        // Async reset in the middle of RUN
        send_only(8'h12, 8'h34, 1'b0, 6'd5);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check_val("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("async_rst_busy",      {31'd0, busy}, 32'd0);
        check_val("async_rst_sum",       {24'd0, out_sum}, 32'd0);
        check_val("async_rst_cout",      {31'd0, out_cout}, 32'd0);
        check_val("async_rst_ovf",       {31'd0, out_ovf}, 32'd0);
        check_val("async_rst_tag",       {26'd0, out_tag}, 32'd0);
        sb.delete();
        last_sum = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("after_rst_busy", {31'd0, busy}, 32'd0);

        do_op(8'hFF, 8'h01, 1'b0, 6'd1,  0);
        do_op(8'h7F, 8'h01, 1'b0, 6'd2,  0);

        // Backpressure, then the next op is accepted normally
        do_op(8'hA5, 8'h3C, 1'b0, 6'd40, 20);
        do_op(8'h10, 8'h20, 1'b1, 6'd41, 0);

        // Random ops
        for (int i = 0; i < 6; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), TAG_W'($urandom),
                  int'($urandom_range(0, 3)));
        end

        // flush while processing bit 3
        send_only(8'h55, 8'h22, 1'b0, 6'd50);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        void'(sb.pop_back());
        check_val("flush_run_valid", {31'd0, out_valid}, 32'd0);
        check_val("flush_run_busy",  {31'd0, busy}, 32'd0);
        check_val("flush_run_ready", {31'd0, in_ready}, 32'd1);
        check_val("flush_run_sum_kept", {24'd0, out_sum}, {24'd0, last_sum});

        // flush while holding a result (with out_ready also high)
        send_only(8'h0F, 8'h0F, 1'b0, 6'd51);
        wait_valid(n);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        void'(sb.pop_back());
        check_val("flush_done_valid", {31'd0, out_valid}, 32'd0);
        check_val("flush_done_busy",  {31'd0, busy}, 32'd0);

        // flush together with an offered op in IDLE: not accepted
        in_valid = 1'b1;
        in_a     = 8'h01;
        in_b     = 8'h02;
        in_sub   = 1'b0;
        in_tag   = 6'd60;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check_val("flush_idle_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        check_val("flush_idle_no_op", {31'd0, seen}, 32'd0);

        do_op(8'hC8, 8'h64, 1'b1, 6'd63, 1);

        check_val("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
